// File: rtl/scope_trigger_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scope_pkg
// Description : Shared types and default widths for the scope trigger/capture
//               block: capture state encoding and sample/address widths.
// Revision    : 1.0 - initial release
// ============================================================================
package scope_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFILL   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POSTFILL  = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/scope_trigger_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : scope_trigger_capture_if
// Description : Sample stream and record readout bundle.
//               sample_valid/sample : one-cycle strobe plus ADC code
//               rd_addr/rd_data     : trigger-aligned readout, 1-cycle latency
//               master = stream source / reader, slave = capture block
// Revision    : 1.0 - initial release
// ============================================================================
interface scope_trigger_capture_if
    import scope_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output sample_valid, sample, rd_addr, input rd_data);
    modport slave  (input sample_valid, sample, rd_addr, output rd_data);
endinterface
`default_nettype wire

// File: rtl/scope_trigger_capture_trig_detect.sv
`default_nettype none
// ============================================================================
// Module      : scope_trig_detect
// Description : Level-crossing detector. Remembers the previous accepted
//               sample and flags a rising or falling crossing of trig_level
//               on the current accepted sample.
// Ports       : clk, reset_n (sync, active-low), clr (forget history),
//               sample_valid/sample (accepted sample), trig_level,
//               trig_falling (0 rising, 1 falling), hit (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module scope_trig_detect
    import scope_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              clr,
    input  wire logic              sample_valid,
    input  wire logic [DATA_W-1:0] sample,
    input  wire logic [DATA_W-1:0] trig_level,
    input  wire logic              trig_falling,
    output logic                   hit
);
    logic [DATA_W-1:0] r_prev;
    logic              r_prev_valid;
    logic              w_rise;
    logic              w_fall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (clr) begin
            r_prev_valid <= 1'b0;
        end else if (sample_valid) begin
            r_prev       <= sample;
            r_prev_valid <= 1'b1;
        end
    end

    assign w_rise = (r_prev <  trig_level) && (sample >= trig_level);
    assign w_fall = (r_prev >= trig_level) && (sample <  trig_level);
    assign hit    = sample_valid && r_prev_valid && (trig_falling ? w_fall : w_rise);

endmodule
`default_nettype wire

// File: rtl/scope_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module      : scope_trigger_capture
// Description : Circular sample capture with pre-trigger fill, level-crossing
//               or forced trigger, post-trigger fill and a frozen record read
//               back through a trigger-aligned address (rd_addr 0 = oldest).
// Ports       : clk, reset_n (sync, active-low)
//               bus (slave)  : sample_valid, sample, rd_addr, rd_data
//               arm          : restart capture (pulse)
//               force_trig   : force trigger on next sample in WAIT_TRIG
//               trig_level, trig_falling, pretrig : trigger setup
//               busy, waiting, done : capture status
// Revision    : 1.0 - initial release
// ============================================================================
module scope_trigger_capture
    import scope_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    scope_trigger_capture_if.slave bus,
    input  wire logic              arm,
    input  wire logic              force_trig,
    input  wire logic [DATA_W-1:0] trig_level,
    input  wire logic              trig_falling,
    input  wire logic [ADDR_W-1:0] pretrig,
    output logic                   busy,
    output logic                   waiting,
    output logic                   done
);
    localparam int c_DEPTH = 1 << ADDR_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_start_ptr;
    logic [ADDR_W-1:0] r_pre_l;
    logic [ADDR_W-1:0] r_post_cnt;
    logic              r_force_pend;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];

    logic              w_capturing;
    logic              w_accept;
    logic              w_hit;
    logic              w_trig;
    logic [ADDR_W-1:0] w_post_init;
    logic [ADDR_W-1:0] w_rd_idx;

    assign w_capturing = (r_state == ST_PREFILL) || (r_state == ST_WAIT_TRIG) ||
                         (r_state == ST_POSTFILL);
    // A sample coinciding with arm belongs to the aborted capture and is dropped.
    assign w_accept    = bus.sample_valid && w_capturing && !arm;
    assign w_trig      = (r_state == ST_WAIT_TRIG) && w_accept && (w_hit || r_force_pend);
    // DEPTH-1-pre_l: the trigger sample plus post fill complete exactly DEPTH samples.
    assign w_post_init = ADDR_W'(c_DEPTH - 1) - r_pre_l;
    assign w_rd_idx    = r_start_ptr + bus.rd_addr;

    scope_trig_detect #(.DATA_W(DATA_W)) u_trig_detect (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr          (arm),
        .sample_valid (w_accept),
        .sample       (bus.sample),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .hit          (w_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:      w_state_nxt = ST_IDLE;
            ST_PREFILL:   if (w_accept && ((r_count + 1'b1) == r_pre_l))
                              w_state_nxt = ST_WAIT_TRIG;
            ST_WAIT_TRIG: if (w_trig)
                              w_state_nxt = (w_post_init == '0) ? ST_DONE : ST_POSTFILL;
            ST_POSTFILL:  if (w_accept && (r_post_cnt == ADDR_W'(1)))
                              w_state_nxt = ST_DONE;
            ST_DONE:      w_state_nxt = ST_DONE;
            default:      w_state_nxt = ST_IDLE;
        endcase
        // arm overrides trigger and completion in the same cycle.
        if (arm) w_state_nxt = (pretrig == '0) ? ST_WAIT_TRIG : ST_PREFILL;
    end

    // pretrig is ADDR_W wide, so it can never exceed DEPTH-1 and needs no clamp.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_start_ptr  <= '0;
            r_pre_l      <= '0;
            r_post_cnt   <= '0;
            r_force_pend <= 1'b0;
        end else if (arm) begin
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_pre_l      <= pretrig;
            r_force_pend <= 1'b0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_accept && (r_state == ST_PREFILL)) r_count <= r_count + 1'b1;
            if (w_accept && (r_state == ST_POSTFILL)) r_post_cnt <= r_post_cnt - 1'b1;
            if (w_trig) begin
                r_start_ptr  <= r_wr_ptr - r_pre_l;
                r_post_cnt   <= w_post_init;
                r_force_pend <= 1'b0;
            end else if ((r_state == ST_WAIT_TRIG) && force_trig) begin
                r_force_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= bus.sample;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_rd_data <= '0;
        else          r_rd_data <= r_mem[w_rd_idx];
    end

    assign bus.rd_data = r_rd_data;
    assign busy        = w_capturing;
    assign waiting     = (r_state == ST_WAIT_TRIG);
    assign done        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_scope_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_scope_trigger_capture
// Description : Self-checking bench for scope_trigger_capture with a 16-deep
//               buffer: reset, rising/falling/forced triggers, prefill
//               crossings, re-arm mid-capture and maximum pretrig.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scope_trigger_capture;
    localparam int DW = 12;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          arm, force_trig, trig_falling;
    logic [DW-1:0] trig_level;
    logic [AW-1:0] pretrig;
    logic          busy, waiting, done;

    scope_trigger_capture_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    scope_trigger_capture #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .arm          (arm),
        .force_trig   (force_trig),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .pretrig      (pretrig),
        .busy         (busy),
        .waiting      (waiting),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] smp;
        logic          exp_busy;
        logic          exp_waiting;
        logic          exp_done;
    } vec_t;

    vec_t vt [21];
    int   exp_rd [DEPTH];
    int   sb [$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input logic b, input logic w, input logic d);
        chk({name, ".busy"}, int'(busy), int'(b));
        chk({name, ".waiting"}, int'(waiting), int'(w));
        chk({name, ".done"}, int'(done), int'(d));
    endtask

    // Called at a negedge; returns at a negedge after the sample was taken.
    task automatic send(input logic [DW-1:0] v, input int gap);
        bus.sample_valid = 1'b1;
        bus.sample       = v;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_arm(input logic [AW-1:0] p);
        arm     = 1'b1;
        pretrig = p;
        @(negedge clk);
        arm     = 1'b0;
    endtask

    // Expected value queued when the address is driven, checked when rd_data lands.
    task automatic rd_all(input string name);
        int e;
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_addr = AW'(i);
            sb.push_back(exp_rd[i]);
            @(negedge clk);
            if (sb.size() == 0) begin
                chk({name, ".sb_empty"}, 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("%s.rd[%0d]", name, i), int'(bus.rd_data), e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; arm = 1'b0; force_trig = 1'b0; trig_falling = 1'b0;
        trig_level = '0; pretrig = '0;
        bus.sample_valid = 1'b0; bus.sample = '0; bus.rd_addr = '0;

        // Rising ramp table: sample n (1-based) is 10*n.
        for (int n = 1; n <= 21; n++) begin
            vt[n-1].smp         = DW'(10 * n);
            vt[n-1].exp_done    = (n == 21);
            vt[n-1].exp_busy    = (n != 21);
            vt[n-1].exp_waiting = (n >= 4) && (n < 10);
        end

        // ---------------- reset ----------------
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.sample_valid = (i != 1);
            bus.sample       = 12'd123;
            @(negedge clk);
        end
        bus.sample_valid = 1'b0;
        chk_status("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.rd_data", int'(bus.rd_data), 0);
        reset_n = 1'b1;
        send(12'd50, 1);
        chk_status("idle_sample", 1'b0, 1'b0, 1'b0);

        // ---------------- rising trigger ----------------
        trig_level = 12'd100; trig_falling = 1'b0;
        do_arm(4'd4);
        chk_status("rise.armed", 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 21; k++) begin
            send(vt[k].smp, 3);
            chk_status($sformatf("rise.s%0d", k + 1),
                       vt[k].exp_busy, vt[k].exp_waiting, vt[k].exp_done);
        end
        send(12'd999, 1);
        chk_status("rise.frozen", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) exp_rd[i] = 60 + 10 * i;
        rd_all("rise");

        // ---------------- falling trigger ----------------
        trig_level = 12'd2048; trig_falling = 1'b1;
        do_arm(4'd0);
        chk_status("fall.armed", 1'b1, 1'b1, 1'b0);
        send(12'd3000, 0); chk("fall.3000.waiting", int'(waiting), 1);
        send(12'd2500, 0); chk("fall.2500.waiting", int'(waiting), 1);
        send(12'd2048, 0); chk("fall.2048.waiting", int'(waiting), 1);
        send(12'd2047, 0); chk_status("fall.2047", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) send(DW'(100 + i), 0);
        chk_status("fall.end", 1'b0, 1'b0, 1'b1);
        exp_rd[0] = 2047;
        for (int i = 1; i < DEPTH; i++) exp_rd[i] = 99 + i;
        rd_all("fall");

        // ---------------- prefill crossing ignored ----------------
        trig_level = 12'd100; trig_falling = 1'b0;
        do_arm(4'd8);
        send(12'd50, 0); send(12'd60, 0); send(12'd150, 0);
        chk_status("pre.cross3", 1'b1, 1'b0, 1'b0);
        send(12'd160, 0); send(12'd170, 0); send(12'd180, 0); send(12'd190, 0);
        chk("pre.s7.waiting", int'(waiting), 0);
        send(12'd200, 0); chk("pre.s8.waiting", int'(waiting), 1);
        send(12'd210, 0); chk("pre.210.waiting", int'(waiting), 1);
        send(12'd50, 0);  chk("pre.50.waiting", int'(waiting), 1);
        send(12'd120, 0); chk_status("pre.trig", 1'b1, 1'b0, 1'b0);

        // ---------------- re-arm in POSTFILL, sample with arm dropped ----------------
        send(12'd130, 0); send(12'd140, 0);
        arm = 1'b1; pretrig = 4'd2; bus.sample_valid = 1'b1; bus.sample = 12'd77;
        @(negedge clk);
        arm = 1'b0; bus.sample_valid = 1'b0;
        chk_status("rearm", 1'b1, 1'b0, 1'b0);
        send(12'd5, 0); chk("rearm.s1.waiting", int'(waiting), 0);
        send(12'd6, 0); chk("rearm.s2.waiting", int'(waiting), 1);

        // ---------------- pretrig = DEPTH-1 ----------------
        do_arm(AW'(DEPTH - 1));
        for (int i = 1; i <= 14; i++) send(DW'(i), 0);
        chk("max.s14.waiting", int'(waiting), 0);
        send(12'd15, 0);
        chk("max.s15.waiting", int'(waiting), 1);
        send(12'd200, 0);
        chk_status("max.trig_done", 1'b0, 1'b0, 1'b1);
        send(12'd999, 0);
        for (int i = 0; i < DEPTH - 1; i++) exp_rd[i] = i + 1;
        exp_rd[DEPTH-1] = 200;
        rd_all("max");

        // ---------------- force trigger ----------------
        trig_level = 12'd4000; trig_falling = 1'b0;
        do_arm(4'd0);
        send(12'd500, 0); send(12'd500, 0);
        chk("force.pre.waiting", int'(waiting), 1);
        force_trig = 1'b1;
        @(negedge clk);
        force_trig = 1'b0;
        chk("force.pulse.waiting", int'(waiting), 1);
        send(12'd510, 0);
        chk_status("force.trig", 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < DEPTH; i++) send(DW'(510 + i), 0);
        chk_status("force.end", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) exp_rd[i] = 510 + i;
        rd_all("force");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scope_trigger_capture.md
Name: scope_trigger_capture

Overview:
Downstream of the ADC serial interface. Consumes the 12-bit sample stream and stores samples in a circular on-chip buffer. After a configurable pre-trigger fill, it waits for a level-crossing trigger, completes the post-trigger fill and freezes the record. The frozen record is read out through a trigger-aligned address port, so rd_addr 0 is the oldest pre-trigger sample.

Parameters:
DATA_W, 12, sample width (matches ADC result width)
ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset_n  in  1  synchronous, active-low reset
sample_valid  in  1  one-cycle strobe; sample is valid this cycle
sample  in  DATA_W  unsigned ADC code
arm  in  1  one-cycle pulse; starts a new capture
force_trig  in  1  one-cycle pulse; trigger on the next accepted sample in WAIT_TRIG
trig_level  in  DATA_W  unsigned trigger threshold
trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger
pretrig  in  ADDR_W  number of samples kept before the trigger sample
rd_addr  in  ADDR_W  readout index relative to record start
rd_data  out  DATA_W  buffer word; registered, 1-cycle latency
busy  out  1  high in PREFILL, WAIT_TRIG and POSTFILL
waiting  out  1  high in WAIT_TRIG only
done  out  1  high in DONE; record is frozen and valid

Behaviour:
- Reset (reset_n=0 at posedge clk): state=IDLE; wr_ptr, count, start_ptr, prev_valid and rd_data are 0; busy, waiting and done are 0. Buffer contents are undefined.
- State machine: IDLE, PREFILL, WAIT_TRIG, POSTFILL, DONE (one-hot or encoded).
- arm, in any state, restarts the capture:
  - wr_ptr=0, count=0, prev_valid=0.
  - pre_l = pretrig, clamped to DEPTH-1.
  - Next state is PREFILL, or WAIT_TRIG if pre_l==0.
  - A sample_valid in the same cycle as arm is dropped.
- Accepted sample: sample_valid=1 in PREFILL, WAIT_TRIG or POSTFILL.
  - Write mem[wr_ptr]=sample and wr_ptr++ (wraps mod DEPTH).
  - prev=sample, prev_valid=1.
  - Samples in IDLE and DONE are ignored; no write occurs.
- PREFILL: count++ per accepted sample. When count reaches pre_l, move to WAIT_TRIG. Crossings during PREFILL never trigger, but they do update prev.
- WAIT_TRIG: keeps writing, so the ring holds the newest samples. Trigger hit on an accepted sample when:
  - rising: prev_valid && prev < trig_level && sample >= trig_level
  - falling: prev_valid && prev >= trig_level && sample < trig_level
  - or force_pend=1
- force_trig sets force_pend in WAIT_TRIG. force_pend is cleared on trigger or on arm. force_trig is ignored in other states.
- On trigger, the trigger sample is written at wr_ptr and then:
  - start_ptr = wr_ptr - pre_l (mod DEPTH)
  - post_cnt = DEPTH-1-pre_l
  - next state is POSTFILL, or DONE if post_cnt==0
- POSTFILL: post_cnt-- per accepted sample. The write of the last sample (post_cnt 1→0) moves the state to DONE in the same cycle.
- DONE: done=1, writes are blocked and the record holds exactly DEPTH samples. The trigger sample is at rd_addr == pre_l.
- Readout:
  - rd_data(t+1) = mem[(start_ptr + rd_addr(t)) mod DEPTH], using a synchronous-read RAM.
  - Readout is legal in any state, but the data is defined only in DONE.
  - Read and write in the same cycle to the same address is not required to be coherent (DONE has no writes).
- Arithmetic: all comparisons are unsigned DATA_W. Pointer arithmetic is ADDR_W-bit modular with no overflow flags.
- Simultaneous events: arm has priority over trigger and over completion. reset_n=0 has priority over everything and aborts mid-capture to IDLE.

Decomposition:
- Package scope_pkg: state enum type, DATA_W and ADDR_W defaults.
- One sub-module, scope_trig_detect: holds the prev/prev_valid registers and the edge comparison, and outputs hit. Inputs: clk, reset_n, clr, sample_valid, sample, trig_level, trig_falling.
- The RAM is inferred inline as a single write port plus a registered read port.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles → busy=0, waiting=0, done=0, rd_data=0; sample_valid pulses cause no state change.
- Rising trigger, ADDR_W=4: pretrig=4, level=100; arm, then ramp sample=10*n with valid every 4th cycle → waiting rises after the 4th sample. The trigger fires on sample 100 and done asserts after sample 210. Readout rd_addr 0..15 = 60,70,...,210; rd_addr 4 = 100.
- Falling edge: trig_falling=1, level=2048, samples 3000,2500,2048,2047 → trigger on 2047. 2048 is not a hit (2500≥2048 but 2048 is not <2048).
- Prefill crossing ignored: pretrig=8, crossing at the 3rd sample → no trigger. waiting=1 after the 8th sample, and a trigger follows only at the next crossing.
- force_trig with constant sample 500 and level 4000, pretrig=0 → trigger on the first sample after force. The record starts with that sample at rd_addr 0.
- Re-arm in POSTFILL and edge values: arm mid-POSTFILL → state PREFILL, done stays 0, old count discarded. With pretrig=DEPTH-1, done asserts on the trigger sample itself.
